mem_arbiter: RTL

Arbitrates one shared single-word memory port between the instruction-cache refill engine and the load/store data port. The icache refill is a locked 4-beat burst; data accesses are single-beat reads or writes. The block sits between both requesters and the external memory interface and owns the per-transaction grant and the burst beat count.

---
 rtl/mem_arbiter_pkg.sv | 25 ++
 rtl/mem_arbiter_if.sv | 47 ++++
 rtl/mem_arbiter_arb_pick.sv | 43 ++++
 rtl/mem_arbiter.sv | 142 ++++++++++++++
 4 files changed

// File: rtl/mem_arbiter_pkg.sv
// Shared types and constants for the memory-port arbiter.
//   XLEN          : data/address width of every bus in the arbiter
//   ARB_BURST_LEN : beats in one icache line refill
//   arb_state_t   : arbiter state encoding, also used as the picker's select
//   mem_req_t     : memory-side request payload driven by the output mux
package mem_arbiter_pkg;

    localparam int unsigned XLEN          = 32;
    localparam int unsigned STRB_W        = 4;
    localparam int unsigned ARB_BURST_LEN = 4;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'b00,
        ARB_GRANT_I = 2'b01,
        ARB_GRANT_D = 2'b10
    } arb_state_t;

    typedef struct packed {
        logic              we;
        logic [XLEN-1:0]   addr;
        logic [XLEN-1:0]   wdata;
        logic [STRB_W-1:0] wstrb;
    } mem_req_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// Bus bundle between the icache refill engine, the load/store data port,
// the external memory port and the arbiter.
//   slave  : arbiter view (takes requests, drives readies and the memory side)
//   master : environment view (requesters and memory)
interface mem_arbiter_if;
    import mem_arbiter_pkg::*;

    logic              ic_req;
    logic [XLEN-1:0]   ic_addr;
    logic              ic_ready;
    logic [XLEN-1:0]   ic_rdata;

    logic              d_req;
    logic              d_we;
    logic [XLEN-1:0]   d_addr;
    logic [XLEN-1:0]   d_wdata;
    logic [STRB_W-1:0] d_wstrb;
    logic              d_ready;
    logic [XLEN-1:0]   d_rdata;

    logic              m_req;
    logic              m_we;
    logic [XLEN-1:0]   m_addr;
    logic [XLEN-1:0]   m_wdata;
    logic [STRB_W-1:0] m_wstrb;
    logic              m_ready;
    logic [XLEN-1:0]   m_rdata;

    modport slave (
        input  ic_req, ic_addr,
        input  d_req, d_we, d_addr, d_wdata, d_wstrb,
        input  m_ready, m_rdata,
        output ic_ready, ic_rdata,
        output d_ready, d_rdata,
        output m_req, m_we, m_addr, m_wdata, m_wstrb
    );

    modport master (
        output ic_req, ic_addr,
        output d_req, d_we, d_addr, d_wdata, d_wstrb,
        output m_ready, m_rdata,
        input  ic_ready, ic_rdata,
        input  d_ready, d_rdata,
        input  m_req, m_we, m_addr, m_wdata, m_wstrb
    );

endinterface

// File: rtl/mem_arbiter_arb_pick.sv
// Combinational priority picker used while the arbiter is idle.
//   i_ic_req : icache refill pending
//   i_d_req  : data access pending
//   i_last_d : previous completed transaction was a data access
//   o_sel    : state to enter next (ARB_IDLE when nothing is pending)
// Optional feature macro: MEM_ARB_RR_EN (alternate icache/data on collision).
module arb_pick
    import mem_arbiter_pkg::*;
(
    input  logic       i_ic_req,
    input  logic       i_d_req,
    input  logic       i_last_d,
    output arb_state_t o_sel
);

`ifdef MEM_ARB_RR_EN
    // On a collision the side that did not go last wins, bounding fetch starvation.
    always_comb begin
        o_sel = ARB_IDLE;
        if (i_ic_req && i_d_req) begin
            o_sel = i_last_d ? ARB_GRANT_I : ARB_GRANT_D;
        end else if (i_d_req) begin
            o_sel = ARB_GRANT_D;
        end else if (i_ic_req) begin
            o_sel = ARB_GRANT_I;
        end
    end
`else
    // Fixed policy: data always beats the icache; history is irrelevant.
    logic w_unused_last_d;
    assign w_unused_last_d = i_last_d;

    always_comb begin
        o_sel = ARB_IDLE;
        if (i_d_req) begin
            o_sel = ARB_GRANT_D;
        end else if (i_ic_req) begin
            o_sel = ARB_GRANT_I;
        end
    end
`endif

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-word memory port between a locked icache refill
// burst and single-beat data reads/writes.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low
//   bus    : mem_arbiter_if.slave (icache, data and memory handshakes)
//   gnt_i  : icache owns the memory port (registered)
//   gnt_d  : data port owns the memory port (registered)
// Optional feature macro: MEM_ARB_RR_EN (round-robin on collisions via last_d).
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int unsigned BURST_LEN = ARB_BURST_LEN,
    parameter int unsigned AW        = XLEN
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus,
    output logic          gnt_i,
    output logic          gnt_d
);

    localparam int unsigned CNT_W = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;

    arb_state_t       r_state;
    logic [CNT_W-1:0] r_beat_cnt;
    logic             r_gnt_i;
    logic             r_gnt_d;

    arb_state_t       w_pick;
    logic             w_last_d;
    logic             w_last_beat;
    logic             w_i_done;
    logic             w_d_done;
    mem_req_t         w_mem;
    logic             w_m_req;

    assign w_last_beat = (r_beat_cnt == CNT_W'(BURST_LEN - 1));
    assign w_i_done    = (r_state == ARB_GRANT_I) && bus.ic_req && bus.m_ready && w_last_beat;
    assign w_d_done    = (r_state == ARB_GRANT_D) && bus.d_req && bus.m_ready;

`ifdef MEM_ARB_RR_EN
    logic r_last_d;

    // Remembers which side completed last so a collision goes the other way.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_last_d <= 1'b0;
        end else if (w_d_done) begin
            r_last_d <= 1'b1;
        end else if (w_i_done) begin
            r_last_d <= 1'b0;
        end
    end

    assign w_last_d = r_last_d;
`else
    assign w_last_d = 1'b0;
`endif

    arb_pick u_pick (
        .i_ic_req (bus.ic_req),
        .i_d_req  (bus.d_req),
        .i_last_d (w_last_d),
        .o_sel    (w_pick)
    );

    // Grant FSM and beat counter; a dropped request ends ownership at once.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= ARB_IDLE;
            r_beat_cnt <= '0;
            r_gnt_i    <= 1'b0;
            r_gnt_d    <= 1'b0;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    r_beat_cnt <= '0;
                    r_state    <= w_pick;
                    r_gnt_i    <= (w_pick == ARB_GRANT_I);
                    r_gnt_d    <= (w_pick == ARB_GRANT_D);
                end
                ARB_GRANT_I: begin
                    if (!bus.ic_req || w_i_done) begin
                        r_state    <= ARB_IDLE;
                        r_beat_cnt <= '0;
                        r_gnt_i    <= 1'b0;
                    end else if (bus.m_ready) begin
                        r_beat_cnt <= r_beat_cnt + CNT_W'(1);
                    end
                end
                ARB_GRANT_D: begin
                    if (!bus.d_req || bus.m_ready) begin
                        r_state <= ARB_IDLE;
                        r_gnt_d <= 1'b0;
                    end
                end
                default: begin
                    r_state    <= ARB_IDLE;
                    r_beat_cnt <= '0;
                    r_gnt_i    <= 1'b0;
                    r_gnt_d    <= 1'b0;
                end
            endcase
        end
    end

    assign gnt_i = r_gnt_i;
    assign gnt_d = r_gnt_d;

    // Memory-side mux follows the owner's request combinationally.
    always_comb begin
        w_mem        = '0;
        w_m_req      = 1'b0;
        bus.ic_ready = 1'b0;
        bus.d_ready  = 1'b0;
        case (r_state)
            ARB_GRANT_I: begin
                w_m_req      = bus.ic_req;
                w_mem.addr   = XLEN'(bus.ic_addr[AW-1:0]);
                bus.ic_ready = bus.m_ready;
            end
            ARB_GRANT_D: begin
                w_m_req      = bus.d_req;
                w_mem.we     = bus.d_we;
                w_mem.addr   = XLEN'(bus.d_addr[AW-1:0]);
                w_mem.wdata  = bus.d_wdata;
                w_mem.wstrb  = bus.d_wstrb;
                bus.d_ready  = bus.m_ready;
            end
            default: ;
        endcase
    end

    assign bus.m_req    = w_m_req;
    assign bus.m_we     = w_mem.we;
    assign bus.m_addr   = w_mem.addr;
    assign bus.m_wdata  = w_mem.wdata;
    assign bus.m_wstrb  = w_mem.wstrb;
    assign bus.ic_rdata = bus.m_rdata;
    assign bus.d_rdata  = bus.m_rdata;

endmodule
